// File: rtl/divider32_iterative.sv
// Sequential radix-2 restoring divider: one quotient bit per clock,
// signed or unsigned operands, valid/ready handshakes on both sides.
module divider32_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Two's-complement negate when en is set, otherwise pass through.
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
      if (en) begin
         neg_if = ~v + WIDTH'(1);
      end else begin
         neg_if = v;
      end
   endfunction

   state_t           state_r;
   state_t           state_next_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] rem_r;        // partial remainder (always < divisor magnitude)
   logic [WIDTH-1:0] quo_r;        // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs_r;        // divisor magnitude
   logic             sign_q_r;
   logic             sign_r_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] rem_next_s;
   logic [WIDTH-1:0] quo_next_s;
   logic             qbit_s;
   logic             last_iter_s;
   logic             div_zero_s;

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);
   assign quotient  = quotient_r;
   assign remainder = remainder_r;

   // One restoring step: shift, trial-subtract on WIDTH+1 bits, keep or restore.
   always_comb begin
      shifted_s   = {rem_r, quo_r[WIDTH-1]};
      trial_s     = shifted_s - {1'b0, dvs_r};
      rem_next_s  = shifted_s[WIDTH-1:0];
      qbit_s      = 1'b0;
      if (!trial_s[WIDTH]) begin
         rem_next_s = trial_s[WIDTH-1:0];
         qbit_s     = 1'b1;
      end else begin
         rem_next_s = shifted_s[WIDTH-1:0];
         qbit_s     = 1'b0;
      end
      quo_next_s  = {quo_r[WIDTH-2:0], qbit_s};
      last_iter_s = (cnt_r == CW'(WIDTH - 1));
      div_zero_s  = (divisor == {WIDTH{1'b0}});
   end

   // Next-state decode for the IDLE/CALC/DONE sequence.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               if (div_zero_s) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = CALC;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         CALC: begin
            if (last_iter_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand capture, iteration datapath and registered result with sign fix-up.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r       <= {CW{1'b0}};
         rem_r       <= {WIDTH{1'b0}};
         quo_r       <= {WIDTH{1'b0}};
         dvs_r       <= {WIDTH{1'b0}};
         sign_q_r    <= 1'b0;
         sign_r_r    <= 1'b0;
         quotient_r  <= {WIDTH{1'b0}};
         remainder_r <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  sign_q_r <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  sign_r_r <= is_signed & dividend[WIDTH-1];
                  quo_r    <= neg_if(dividend, is_signed & dividend[WIDTH-1]);
                  dvs_r    <= neg_if(divisor, is_signed & divisor[WIDTH-1]);
                  rem_r    <= {WIDTH{1'b0}};
                  cnt_r    <= {CW{1'b0}};
                  if (div_zero_s) begin
                     // Divide-by-zero: all-ones quotient, untouched dividend as remainder.
                     quotient_r  <= {WIDTH{1'b1}};
                     remainder_r <= dividend;
                  end
               end
            end
            CALC: begin
               rem_r <= rem_next_s;
               quo_r <= quo_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (last_iter_s) begin
                  quotient_r  <= neg_if(quo_next_s, sign_q_r);
                  remainder_r <= neg_if(rem_next_s, sign_r_r);
               end
            end
            DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: doc/divider32_iterative.md
Name: divider32_iterative

Overview:
- Sequential radix-2 restoring integer divider; inverse companion to the combinational Wallace-tree multiplier in the M-extension datapath.
- Accepts one dividend/divisor pair per operation through a valid/ready handshake.
- Computes quotient and remainder, signed or unsigned, one quotient bit per cycle.
- Returns results through a second valid/ready handshake to the execute stage.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider can accept operands (high only in IDLE).
- is_signed  input  1  1 = two's-complement division; 0 = unsigned. Sampled at accept.
- dividend  input  WIDTH  dividend, sampled at accept.
- divisor  input  WIDTH  divisor, sampled at accept.
- out_valid  output  1  quotient/remainder valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.

Behaviour:
- Reset: rst_n sampled low at a rising edge forces state IDLE, out_valid=0, quotient=0, remainder=0, iteration counter=0. Applies from any state, including mid-CALC; the in-flight operation is discarded with no output. in_ready=1 on the first cycle after reset deasserts.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE, in_valid=1:
  - Accept on that edge.
  - Latch sign_q = is_signed & dividend[MSB] ^ divisor[MSB] and sign_r = is_signed & dividend[MSB].
  - Latch the magnitudes: two's-complement negate an operand when is_signed and its MSB is set; otherwise pass it through.
  - Latch the original dividend.
  - If divisor==0, go to DONE. Otherwise clear the partial remainder, set counter=0 and go to CALC.
- CALC, one iteration per edge:
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor magnitude from the WIDTH+1-bit partial remainder.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - counter increments. On the edge performing iteration WIDTH-1, register the final outputs and go to DONE.
- Output sign fix on that final edge:
  - quotient = sign_q ? -quo : quo.
  - remainder = sign_r ? -rem : rem.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge (32 for the default). Divide-by-zero: out_valid rises 1 cycle after accept.
- Divide-by-zero (signed or unsigned): quotient = all ones (0xFFFFFFFF); remainder = original dividend, unmodified.
- Signed overflow (0x80000000 / 0xFFFFFFFF, is_signed=1): quotient=0x80000000, remainder=0. This falls out of unsigned magnitude arithmetic with the WIDTH+1-bit remainder and needs no special-case logic.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- DONE: quotient, remainder and out_valid hold stable until out_ready=1 at an edge.
  - On that edge return to IDLE with out_valid=0 next cycle.
  - quotient and remainder retain their values until the next result is written.
- No new operand can be accepted in the same cycle a result is consumed; the next accept is possible one cycle later.
- in_valid is ignored outside IDLE; operand inputs may change freely after accept.
- is_signed=0: no negation at input or output; MSBs are treated as magnitude.

Test Plan:
- Unsigned 100 / 7, is_signed=0 -> quotient=14, remainder=2; out_valid exactly 32 cycles after accept; in_ready=0 throughout CALC.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1.
- Divisor 0: unsigned 0x12345678 / 0 and signed 0x80000001 / 0 -> quotient=0xFFFFFFFF, remainder=dividend; out_valid 1 cycle after accept.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned same operands -> quotient=0, remainder=0x80000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a pending in_valid is not accepted. Raise out_ready -> IDLE next cycle, then the operand is accepted.
- Reset mid-op: assert rst_n=0 for one edge at iteration 15 -> out_valid=0, quotient=remainder=0, in_ready=1 next cycle. A following 0xFFFFFFFF / 0x10 unsigned gives quotient=0x0FFFFFFF, remainder=0xF.
